alu_bist_scheduler: RTL and testbench

ALU_BIST_SCHEDULER -- requirements
Module: alu_bist_scheduler

---
 rtl/alu_bist_scheduler_pkg.sv | 28 ++
 rtl/bist_misr_core.sv | 39 +++
 rtl/alu_bist_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_alu_bist_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_scheduler_pkg.sv
// rtl/alu_bist_scheduler_pkg.sv - shared FSM encoding, LFSR/MISR tap constants and index width helper
package alu_bist_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RUN   = 2'd2,
      ST_CHECK = 2'd3
   } bist_state_e;

   // Feedback tap masks, bit n set means register bit n joins the XOR.
   localparam logic [63:0] TAPS_W16 = 64'h0000_0000_0000_D008;
   localparam logic [63:0] TAPS_W32 = 64'h0000_0000_8020_0003;
   localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

   function automatic logic [63:0] bist_taps(input int unsigned width);
      case (width)
         16:      return TAPS_W16;
         64:      return TAPS_W64;
         default: return TAPS_W32;
      endcase
   endfunction

   function automatic int unsigned bist_idxw(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bist_misr_core.sv
// rtl/bist_misr_core.sv - multiple-input signature register compacting the unit-under-test outputs
module bist_misr_core
   import alu_bist_scheduler_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] data,
   input  logic             carry,
   output logic [WIDTH-1:0] sig
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(bist_taps(WIDTH));

   logic [WIDTH-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = '0;
      end else if (enable) begin
         sig_d = {sig_q[WIDTH-2:0], ^(sig_q & TAPS)} ^ data ^ {{(WIDTH-1){1'b0}}, carry};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/alu_bist_scheduler.sv
// rtl/alu_bist_scheduler.sv - periodic online self-test of redundant ALUs with round-robin unit rotation
module alu_bist_scheduler
   import alu_bist_scheduler_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned NUM_UNITS = 3,
   parameter int unsigned INTERVAL  = 65535,
   parameter int unsigned WINDOW    = 256,
   parameter logic [31:0] SEED      = 32'hACE1,
   localparam int unsigned IDXW     = bist_idxw(NUM_UNITS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       test_en_in,
   input  logic                       bist_gnt,
   input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
   input  logic [NUM_UNITS-1:0]       unit_carry,
   input  logic [WIDTH-1:0]           golden_sig,
   output logic                       bist_req,
   output logic                       test_active,
   output logic [IDXW-1:0]            tut_sel,
   output logic [IDXW-1:0]            active_sel,
   output logic [WIDTH-1:0]           lfsr_out,
   output logic [2:0]                 op_out,
   output logic [NUM_UNITS-1:0]       fault_mask,
   output logic                       all_failed,
   output logic                       test_done,
   output logic [WIDTH-1:0]           sig_out
);

   localparam int unsigned      TW     = $clog2(INTERVAL + 1);
   localparam int unsigned      CW     = $clog2(WINDOW + 1);
   localparam logic [WIDTH-1:0] TAPS   = WIDTH'(bist_taps(WIDTH));
   localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

   bist_state_e          state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [CW-1:0]        wcnt_q, wcnt_d;
   logic [WIDTH-1:0]     lfsr_q, lfsr_d;
   logic [IDXW-1:0]      tut_sel_q, tut_sel_d;
   logic [NUM_UNITS-1:0] fault_mask_q, fault_mask_d;
   logic [WIDTH-1:0]     sig_out_q, sig_out_d;
   logic                 bist_req_q, bist_req_d;
   logic                 test_active_q, test_active_d;
   logic                 test_done_q, test_done_d;

   logic [WIDTH-1:0]     tut_data;
   logic                 tut_carry;
   logic [WIDTH-1:0]     misr_sig;
   logic                 misr_clear, misr_enable;
   int unsigned          healthy;
   logic                 nxt_found, act_found;

   assign misr_clear  = (state_q == ST_REQ) && bist_gnt;
   assign misr_enable = (state_q == ST_RUN);

   bist_misr_core #(.WIDTH(WIDTH)) u_misr (
      .clk    (clk),
      .rst    (rst),
      .clear  (misr_clear),
      .enable (misr_enable),
      .data   (tut_data),
      .carry  (tut_carry),
      .sig    (misr_sig)
   );

   always_comb begin
      healthy   = 0;
      tut_data  = '0;
      tut_carry = 1'b0;
      for (int unsigned j = 0; j < NUM_UNITS; j++) begin
         if (!fault_mask_q[j]) healthy++;
         if (tut_sel_q == IDXW'(j)) begin
            tut_data  = unit_result[j*WIDTH +: WIDTH];
            tut_carry = unit_carry[j];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      wcnt_d        = wcnt_q;
      lfsr_d        = lfsr_q;
      tut_sel_d     = tut_sel_q;
      fault_mask_d  = fault_mask_q;
      sig_out_d     = sig_out_q;
      bist_req_d    = 1'b0;
      test_active_d = 1'b0;
      test_done_d   = 1'b0;
      nxt_found     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (healthy < 2) begin
               timer_d = '0;
            end else if (timer_q == TW'(INTERVAL - 1) || test_en_in) begin
               state_d    = ST_REQ;
               timer_d    = '0;
               bist_req_d = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_REQ: begin
            bist_req_d = 1'b1;
            if (bist_gnt) begin
               state_d       = ST_RUN;
               bist_req_d    = 1'b0;
               test_active_d = 1'b1;
               lfsr_d        = SEED_W;
               wcnt_d        = '0;
            end
         end
         ST_RUN: begin
            lfsr_d        = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
            wcnt_d        = wcnt_q + CW'(1);
            test_active_d = 1'b1;
            if (wcnt_q == CW'(WINDOW - 1)) begin
               state_d       = ST_CHECK;
               test_active_d = 1'b0;
            end
         end
         ST_CHECK: begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            test_done_d = 1'b1;
            sig_out_d   = misr_sig;
            for (int unsigned j = 0; j < NUM_UNITS; j++) begin
               if (tut_sel_q == IDXW'(j) && misr_sig != golden_sig) fault_mask_d[j] = 1'b1;
            end
            // Rotate to the next unit still healthy after this verdict; stay put if none is.
            for (int unsigned k = 1; k <= NUM_UNITS; k++) begin
               for (int unsigned j = 0; j < NUM_UNITS; j++) begin
                  if (!nxt_found && j == (32'(tut_sel_q) + k) % NUM_UNITS && !fault_mask_d[j]) begin
                     tut_sel_d = IDXW'(j);
                     nxt_found = 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         wcnt_q        <= '0;
         lfsr_q        <= SEED_W;
         tut_sel_q     <= '0;
         fault_mask_q  <= '0;
         sig_out_q     <= '0;
         bist_req_q    <= 1'b0;
         test_active_q <= 1'b0;
         test_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         wcnt_q        <= wcnt_d;
         lfsr_q        <= lfsr_d;
         tut_sel_q     <= tut_sel_d;
         fault_mask_q  <= fault_mask_d;
         sig_out_q     <= sig_out_d;
         bist_req_q    <= bist_req_d;
         test_active_q <= test_active_d;
         test_done_q   <= test_done_d;
      end
   end

   // The unit under test is withheld from the pipeline only while it is being exercised.
   always_comb begin
      active_sel = '0;
      act_found  = 1'b0;
      for (int unsigned j = 0; j < NUM_UNITS; j++) begin
         if (!act_found && !fault_mask_q[j] && !(state_q == ST_RUN && tut_sel_q == IDXW'(j))) begin
            active_sel = IDXW'(j);
            act_found  = 1'b1;
         end
      end
   end

   assign bist_req    = bist_req_q;
   assign test_active = test_active_q;
   assign tut_sel     = tut_sel_q;
   assign lfsr_out    = lfsr_q;
   assign op_out      = lfsr_q[2:0];
   assign fault_mask  = fault_mask_q;
   assign all_failed  = &fault_mask_q;
   assign test_done   = test_done_q;
   assign sig_out     = sig_out_q;

endmodule

// File: tb/tb_alu_bist_scheduler.sv
// tb/tb_alu_bist_scheduler.sv - randomized self-checking bench against a scenario-level scheduler model
module tb_alu_bist_scheduler;

   localparam int          W    = 32;
   localparam int          NU   = 3;
   localparam int          INTV = 16;
   localparam int          WIN  = 8;
   localparam logic [31:0] SEED = 32'hACE1;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic            clk, rst, test_en_in, bist_gnt;
   logic [NU*W-1:0] unit_result;
   logic [NU-1:0]   unit_carry;
   logic [W-1:0]    golden_sig;
   logic            bist_req, test_active, all_failed, test_done;
   logic [1:0]      tut_sel, active_sel;
   logic [W-1:0]    lfsr_out, sig_out;
   logic [2:0]      op_out;
   logic [NU-1:0]   fault_mask;

   logic [NU-1:0]   fault_en;
   logic [NU-1:0]   m_mask;
   int              m_tut, next_req_at;
   int              n_cmp, n_bad;

   alu_bist_scheduler #(
      .WIDTH(W), .NUM_UNITS(NU), .INTERVAL(INTV), .WINDOW(WIN), .SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .test_en_in(test_en_in), .bist_gnt(bist_gnt),
      .unit_result(unit_result), .unit_carry(unit_carry), .golden_sig(golden_sig),
      .bist_req(bist_req), .test_active(test_active), .tut_sel(tut_sel),
      .active_sel(active_sel), .lfsr_out(lfsr_out), .op_out(op_out),
      .fault_mask(fault_mask), .all_failed(all_failed), .test_done(test_done),
      .sig_out(sig_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {a, 1'b0};
         3'd6:    return {a[0], 1'b0, a[31:1]};
         default: return {1'b0, a} + 33'd1;
      endcase
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] p);
      return {p[30:0], ^(p & TAPS)};
   endfunction

   function automatic logic [31:0] sig_model(input bit faulty);
      logic [31:0] p, s;
      logic [32:0] r;
      p = SEED;
      s = '0;
      for (int j = 0; j < WIN; j++) begin
         r = alu_model(p, ~p, p[2:0]);
         if (faulty) r[5] = 1'b1;
         s = {s[30:0], ^(s & TAPS)} ^ r[31:0] ^ {31'b0, r[32]};
         p = lfsr_next(p);
      end
      return s;
   endfunction

   function automatic int next_healthy(input int t, input logic [NU-1:0] m);
      for (int k = 1; k <= NU; k++) if (!m[(t + k) % NU]) return (t + k) % NU;
      return t;
   endfunction

   function automatic int model_active(input bit in_run);
      for (int i = 0; i < NU; i++) if (!m_mask[i] && !(in_run && i == m_tut)) return i;
      return 0;
   endfunction

   function automatic int healthy_cnt();
      int h;
      h = 0;
      for (int i = 0; i < NU; i++) if (!m_mask[i]) h++;
      return h;
   endfunction

   // Redundant ALUs: every unit computes the same op; a faulty unit has result bit 5 stuck at 1.
   always_comb begin : alu_units
      logic [32:0] r;
      unit_result = '0;
      unit_carry  = '0;
      r = alu_model(lfsr_out, ~lfsr_out, op_out);
      for (int i = 0; i < NU; i++) begin
         unit_result[i*W +: W] = fault_en[i] ? (r[31:0] | 32'h20) : r[31:0];
         unit_carry[i]         = r[32];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      m_mask = '0;
      m_tut = 0;
      next_req_at = INTV;
   endtask

   task automatic reset_checks();
      chk("rst_bist_req", bist_req, 0);
      chk("rst_test_active", test_active, 0);
      chk("rst_test_done", test_done, 0);
      chk("rst_active_sel", active_sel, 0);
      chk("rst_fault_mask", fault_mask, 0);
      chk("rst_sig_out", sig_out, 0);
      chk("rst_lfsr", lfsr_out, SEED);
      chk("rst_tut_sel", tut_sel, 0);
      chk("rst_all_failed", all_failed, 0);
   endtask

   task automatic run_test(input bit chk_timing, input int gnt_delay, input bit pulse_en);
      int cnt, spur;
      logic [31:0] exp_sig;
      cnt = 0;
      spur = 0;
      while (bist_req !== 1'b1 && cnt < 100) begin
         step();
         cnt++;
         if (test_done) spur++;
      end
      chk("req_seen", bist_req, 1);
      if (bist_req !== 1'b1) return;
      if (chk_timing) chk("req_latency", cnt, next_req_at);
      chk("no_stray_done", spur, 0);
      chk("tut_sel_pre", tut_sel, m_tut);
      for (int i = 0; i < gnt_delay; i++) begin
         step();
         chk("hold_req", bist_req, 1);
         chk("hold_inactive", test_active, 0);
         chk("hold_active_sel", active_sel, model_active(0));
      end
      bist_gnt = 1'b1;
      step();
      chk("run_active", test_active, 1);
      chk("run_req_low", bist_req, 0);
      chk("run_tut_sel", tut_sel, m_tut);
      chk("run_active_sel", active_sel, model_active(1));
      chk("run_lfsr_seed", lfsr_out, SEED);
      chk("run_op", op_out, SEED[2:0]);
      bist_gnt = 1'($urandom_range(0, 1));
      cnt = 1;
      while (!test_done && cnt < 40) begin
         if (pulse_en && cnt == 3) test_en_in = 1'b1;
         step();
         cnt++;
         test_en_in = 1'b0;
      end
      bist_gnt = 1'b0;
      chk("done_latency", cnt, WIN + 2);
      exp_sig = sig_model(fault_en[m_tut]);
      if (exp_sig != golden_sig) m_mask[m_tut] = 1'b1;
      m_tut = next_healthy(m_tut, m_mask);
      chk("sig_out", sig_out, exp_sig);
      chk("fault_mask", fault_mask, m_mask);
      chk("tut_sel_post", tut_sel, m_tut);
      chk("active_sel_post", active_sel, model_active(0));
      chk("all_failed", all_failed, &m_mask);
      step();
      chk("done_pulse", test_done, 0);
      next_req_at = INTV - 1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int seen;
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      test_en_in = 1'b0;
      bist_gnt = 1'b0;
      fault_en = '0;
      golden_sig = sig_model(1'b0);
      step();
      do_reset();
      reset_checks();

      // fault-free auto start, then a manual start at timer 3 with a stray request during RUN
      run_test(1, 0, 0);
      step();
      step();
      test_en_in = 1'b1;
      step();
      test_en_in = 1'b0;
      chk("en_req", bist_req, 1);
      run_test(0, 0, 1);
      run_test(1, 0, 0);

      // unit 0 faulty: it is caught when its turn comes, then unit 1 is tested and found faulty
      fault_en = 3'b001;
      run_test(1, 1, 0);
      chk("u0_mask", fault_mask, 3'b001);
      chk("u0_active_sel", active_sel, 1);
      fault_en = 3'b011;
      run_test(1, 0, 0);
      chk("u01_mask", fault_mask, 3'b011);
      chk("u01_active_sel", active_sel, 2);
      test_en_in = 1'b1;
      step();
      test_en_in = 1'b0;
      seen = 0;
      repeat (30) begin
         step();
         if (bist_req) seen++;
      end
      chk("degraded_no_req", seen, 0);

      // reset in the middle of a test on faulty unit 0
      do_reset();
      reset_checks();
      fault_en = 3'b001;
      seen = 0;
      while (!bist_req && seen < 100) begin
         step();
         seen++;
      end
      chk("mr_req_latency", seen, INTV);
      bist_gnt = 1'b1;
      step();
      bist_gnt = 1'b0;
      repeat (4) step();
      chk("mr_in_run", test_active, 1);
      do_reset();
      reset_checks();

      // grant withheld for 20 cycles
      run_test(1, 20, 0);

      fault_en = '0;
      for (int it = 0; it < 10; it++) begin
         if (healthy_cnt() >= 2) begin
            for (int i = 0; i < NU; i++) fault_en[i] = ($urandom_range(0, 3) == 0);
            run_test(1, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
         end else begin
            test_en_in = 1'b1;
            step();
            test_en_in = 1'b0;
            seen = 0;
            repeat (20) begin
               step();
               if (bist_req) seen++;
            end
            chk("rand_degraded_no_req", seen, 0);
            do_reset();
            reset_checks();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
